// File: rtl/ram2x8_arbiter.sv
// Round-robin arbiter/sequencer for a 2-word RAM: init sweep of both words, then
// serialises read/write transactions from two requesters onto the single RAM port.
module ram2x8_arbiter #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             req0,
  input  logic             req1,
  input  logic             wr0,
  input  logic             wr1,
  input  logic             addr0,
  input  logic             addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             ram_we,
  output logic             ram_addr,
  output logic [WIDTH-1:0] ram_din,
  input  logic [WIDTH-1:0] ram_dout,
  output logic [2:0]       dbg_state_o
);

  // Handshake: a requester holds req/wr/addr/wdata stable until its one-cycle ack;
  // req still high in the IDLE cycle after ack starts a new transaction.
  typedef enum logic [2:0] {
    S_INIT0  = 3'd0,
    S_INIT1  = 3'd1,
    S_IDLE   = 3'd2,
    S_ACCESS = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic             wr_q, wr_d;
  logic             addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             pick;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= S_INIT0;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    // On a tie the requester not served last wins; otherwise the sole requester.
    pick    = (req0 && req1) ? ~last_q : req1;
    case (state_q)
      S_INIT0: state_d = S_INIT1;
      S_INIT1: state_d = S_IDLE;
      S_IDLE: begin
        if (req0 || req1) begin
          id_d    = pick;
          wr_d    = pick ? wr1 : wr0;
          addr_d  = pick ? addr1 : addr0;
          wdata_d = pick ? wdata1 : wdata0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!wr_q) rdata_d = ram_dout;
        state_d = S_RESP;
      end
      S_RESP: begin
        last_d  = id_q;
        state_d = S_IDLE;
      end
      default: state_d = S_INIT0;
    endcase
  end

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = 1'b0;
    ram_din  = '0;
    case (state_q)
      S_INIT0: begin
        ram_we  = 1'b1;
        ram_din = INIT_VALUE;
      end
      S_INIT1: begin
        ram_we   = 1'b1;
        ram_addr = 1'b1;
        ram_din  = INIT_VALUE;
      end
      S_ACCESS: begin
        ram_we   = wr_q;
        ram_addr = addr_q;
        ram_din  = wdata_q;
      end
      default: ;
    endcase
    // Gate the write strobe so nothing is committed while reset is asserted.
    ram_we = ram_we & clear_n;
  end

  assign gnt0        = ((state_q == S_ACCESS) || (state_q == S_RESP)) && !id_q;
  assign gnt1        = ((state_q == S_ACCESS) || (state_q == S_RESP)) &&  id_q;
  assign ack0        = (state_q == S_RESP) && !id_q;
  assign ack1        = (state_q == S_RESP) &&  id_q;
  assign busy        = (state_q == S_INIT0) || (state_q == S_INIT1);
  assign rdata       = rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram2x8_arbiter.sv
// Directed bench for ram2x8_arbiter with a behavioural 2x8 RAM attached to its port.
module tb_ram2x8_arbiter;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       req0, req1, wr0, wr1, addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, ack0, ack1, busy, ram_we, ram_addr;
  logic [7:0] rdata, ram_din, ram_dout;
  logic [2:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Non-zero power-up contents so the init sweep is observable.
  logic [7:0] mem [2] = '{8'h5A, 8'hA5};

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;
  assign ram_dout = mem[ram_addr];

  ram2x8_arbiter #(.WIDTH(8), .INIT_VALUE(8'h00)) dut (
    .clk(clk), .clear_n(clear_n),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .busy(busy),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .dbg_state_o(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Single-requester transaction; starts and ends at a negedge in IDLE.
  task automatic txn(input logic id, input logic wr, input logic a, input logic [7:0] wd,
                     input logic [7:0] exp_rd);
    if (id) begin req1 = 1'b1; wr1 = wr; addr1 = a; wdata1 = wd; end
    else    begin req0 = 1'b1; wr0 = wr; addr0 = a; wdata0 = wd; end
    @(negedge clk);
    check("acc_gnt",   id ? gnt1 : gnt0, 1);
    check("acc_ogtn",  id ? gnt0 : gnt1, 0);
    check("acc_we",    ram_we, wr);
    check("acc_addr",  ram_addr, a);
    check("acc_ack",   ack0 | ack1, 0);
    if (wr) check("acc_din", ram_din, wd);
    @(negedge clk);
    check("resp_ack",  id ? ack1 : ack0, 1);
    check("resp_oack", id ? ack0 : ack1, 0);
    check("resp_gnt",  id ? gnt1 : gnt0, 1);
    check("resp_we",   ram_we, 0);
    check("resp_rd",   rdata, exp_rd);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check("idle_ack",  ack0 | ack1, 0);
    check("idle_gnt",  gnt0 | gnt1, 0);
  endtask

  initial begin
    clear_n = 1'b0;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; addr0 = 0; addr1 = 0;
    wdata0 = 8'h00; wdata1 = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_we",    ram_we, 0);
    check("rst_gnt",   {gnt0, gnt1}, 0);
    check("rst_ack",   {ack0, ack1}, 0);
    check("rst_rdata", rdata, 0);

    // Init sweep
    clear_n = 1'b1;
    #1;
    check("init0_busy", busy, 1);
    check("init0_we",   ram_we, 1);
    check("init0_addr", ram_addr, 0);
    check("init0_din",  ram_din, 8'h00);
    @(negedge clk);
    check("init1_busy", busy, 1);
    check("init1_we",   ram_we, 1);
    check("init1_addr", ram_addr, 1);
    @(negedge clk);
    check("idle_busy",  busy, 0);
    check("idle_we",    ram_we, 0);
    check("init_mem0",  mem[0], 8'h00);
    check("init_mem1",  mem[1], 8'h00);
    check("init_ack",   {ack0, ack1}, 0);

    // Tie: both read continuously; acks alternate 0,1,0,1 every 3 cycles
    req0 = 1; wr0 = 0; addr0 = 0;
    req1 = 1; wr1 = 0; addr1 = 1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("tie_ack0", ack0, (k == 2 || k == 8));
      check("tie_ack1", ack1, (k == 5 || k == 11));
      check("tie_gnt0", gnt0, (k == 1 || k == 2 || k == 7 || k == 8));
      check("tie_gnt1", gnt1, (k == 4 || k == 5 || k == 10 || k == 11));
      check("tie_both", gnt0 & gnt1, 0);
      if (ack0 || ack1) check("tie_rdata", rdata, 8'h00);
      if (k == 11) begin req0 = 0; req1 = 0; end
    end

    // Single write / read by requester 0
    txn(1'b0, 1'b1, 1'b1, 8'hCC, 8'h00);
    check("wr_mem1", mem[1], 8'hCC);
    txn(1'b0, 1'b0, 1'b1, 8'h00, 8'hCC);

    // Cross-requester data and rdata stability across a write
    txn(1'b1, 1'b1, 1'b0, 8'hAA, 8'hCC);
    txn(1'b0, 1'b0, 1'b0, 8'h00, 8'hAA);
    txn(1'b1, 1'b1, 1'b1, 8'h55, 8'hAA);
    check("x_mem1", mem[1], 8'h55);

    // Back-to-back: req1 held across ack1
    req1 = 1; wr1 = 1; addr1 = 1; wdata1 = 8'h33;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("b2b_ack1", ack1, (k % 3 == 2));
      check("b2b_gnt0", gnt0, 0);
      if (k == 8) req1 = 0;
    end
    check("b2b_mem1",  mem[1], 8'h33);
    check("b2b_rdata", rdata, 8'hAA);

    // Reset during a write in ACCESS
    req0 = 1; wr0 = 1; addr0 = 0; wdata0 = 8'hFF;
    @(negedge clk);
    check("mid_we_pre", ram_we, 1);
    clear_n = 1'b0;
    #1;
    check("mid_we_rst", ram_we, 0);
    check("mid_gnt",    gnt0, 0);
    req0 = 0;
    @(negedge clk);
    check("mid_ack",    {ack0, ack1}, 0);
    check("mid_mem0",   mem[0], 8'hAA);
    check("mid_rdata",  rdata, 8'h00);
    clear_n = 1'b1;
    #1;
    check("re_busy",    busy, 1);
    @(negedge clk);
    check("re_addr1",   ram_addr, 1);
    @(negedge clk);
    check("re_busy_lo", busy, 0);
    check("re_mem0",    mem[0], 8'h00);
    txn(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
